// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage sitting directly after fetch.
//
// Registers the instruction word returned by memory and the matching
// PC+1 from fetch. Decodes the execute, writeback and memory-access control
// words in the same edge, so every output is a plain register with a single
// cycle of latency and no combinational path from the inputs.
//
// Ports
//   clk            in   1   clock, all state changes on posedge
//   rst            in   1   synchronous reset, active-low
//   enable_decode  in   1   1 = capture instr_dout / npc_in, 0 = hold
//   flush          in   1   1 = replace stage contents with a NOP bubble
//   instr_dout     in   16  instruction word for the current PC
//   npc_in         in   16  PC+1 from fetch
//   ir             out  16  registered instruction
//   npc_out        out  16  registered npc
//   e_control      out  6   {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}
//   w_control      out  2   00 ALU, 01 PC (LEA), 10 memory data
//   mem_control    out  1   1 = indirect access (LDI/STI)
//   ir_valid       out  1   stage holds a real, legal instruction
//   illegal        out  1   sticky unsupported-opcode flag, cleared by reset only
module lc3_decode #(
    parameter logic [15:0] RESET_NPC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_decode,
    input  logic        flush,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] ir,
    output logic [15:0] npc_out,
    output logic [5:0]  e_control,
    output logic [1:0]  w_control,
    output logic        mem_control,
    output logic        ir_valid,
    output logic        illegal
);

    logic [15:0] ir_q, ir_d;
    logic [15:0] npc_q, npc_d;
    logic [5:0]  e_q, e_d;
    logic [1:0]  w_q, w_d;
    logic        mem_q, mem_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;

    // Decode of the incoming word; only used when the stage captures.
    logic [5:0]  dec_e;
    logic [1:0]  dec_w;
    logic        dec_mem;
    logic        dec_legal;

    always_comb begin
        dec_e     = 6'b000000;
        dec_w     = 2'b00;
        dec_mem   = 1'b0;
        dec_legal = 1'b1;
        case (instr_dout[15:12])
            // ALU ops: op2sel picks SR2 only in register mode (IR[5]=0).
            4'b0001: dec_e = {2'b00, 2'b00, 1'b0, ~instr_dout[5]};
            4'b0101: dec_e = {2'b01, 2'b00, 1'b0, ~instr_dout[5]};
            4'b1001: dec_e = 6'b100000;
            4'b0000: dec_e = 6'b000110;
            4'b1100: dec_e = 6'b001100;
            4'b0010: begin dec_e = 6'b000110; dec_w = 2'b10; end
            4'b0110: begin dec_e = 6'b001000; dec_w = 2'b10; end
            4'b1010: begin dec_e = 6'b000110; dec_w = 2'b10; dec_mem = 1'b1; end
            4'b1110: begin dec_e = 6'b000110; dec_w = 2'b01; end
            4'b0011: dec_e = 6'b000110;
            4'b0111: dec_e = 6'b001000;
            4'b1011: begin dec_e = 6'b000110; dec_mem = 1'b1; end
            // JSR, RTI, reserved and TRAP are not supported by this core.
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        ir_d      = ir_q;
        npc_d     = npc_q;
        e_d       = e_q;
        w_d       = w_q;
        mem_d     = mem_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (flush) begin
            // Bubble: opcode 0000 with nzp=000 is a branch that never fires.
            ir_d    = 16'h0000;
            e_d     = 6'b000000;
            w_d     = 2'b00;
            mem_d   = 1'b0;
            valid_d = 1'b0;
        end else if (enable_decode) begin
            ir_d      = instr_dout;
            npc_d     = npc_in;
            e_d       = dec_legal ? dec_e   : 6'b000000;
            w_d       = dec_legal ? dec_w   : 2'b00;
            mem_d     = dec_legal ? dec_mem : 1'b0;
            valid_d   = dec_legal;
            illegal_d = illegal_q | ~dec_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_q      <= 16'h0000;
            npc_q     <= RESET_NPC;
            e_q       <= 6'b000000;
            w_q       <= 2'b00;
            mem_q     <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            npc_q     <= npc_d;
            e_q       <= e_d;
            w_q       <= w_d;
            mem_q     <= mem_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign ir          = ir_q;
    assign npc_out     = npc_q;
    assign e_control   = e_q;
    assign w_control   = w_q;
    assign mem_control = mem_q;
    assign ir_valid    = valid_q;
    assign illegal     = illegal_q;

endmodule
